// File: rtl/mem_ctrl_pkg.sv
// Shared constants for the memory controller: FSM encoding, access-size codes
// and the memory-mapped IO decode.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_INST  = 2'd1,
    ST_LOAD  = 2'd2,
    ST_STORE = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  localparam logic [2:0] INST_BYTES = 3'd4;

  // Byte addresses whose [IO_ADDR_HI:IO_ADDR_LO] equal IO_SEL target the UART.
  localparam int         IO_ADDR_HI = 17;
  localparam int         IO_ADDR_LO = 16;
  localparam logic [1:0] IO_SEL     = 2'b11;

  function automatic logic [2:0] size_bytes(input logic [1:0] size);
    case (size)
      SIZE_BYTE: size_bytes = 3'd1;
      SIZE_HALF: size_bytes = 3'd2;
      default:   size_bytes = 3'd4;
    endcase
  endfunction

endpackage

// File: rtl/mem_ctrl.sv
// Byte-serial memory controller arbitrating instruction fetches and LSB
// loads/stores onto a single 8-bit RAM port with one-cycle read latency.
module mem_ctrl
  import mem_ctrl_pkg::*;
(
  input  logic        clk,
  input  logic        rst,
  input  logic        rdy,
  input  logic        jump_wrong,
  input  logic        inst_req_in,
  input  logic [31:0] inst_pc_in,
  output logic        inst_done_out,
  output logic [31:0] inst_out,
  input  logic        lsb_req_in,
  input  logic        lsb_we_in,
  input  logic [31:0] lsb_addr_in,
  input  logic [1:0]  lsb_size_in,
  input  logic [31:0] lsb_data_in,
  output logic        lsb_done_out,
  output logic [31:0] lsb_data_out,
  input  logic [7:0]  mem_din,
  output logic [7:0]  mem_dout,
  output logic [31:0] mem_a,
  output logic        mem_wr,
  input  logic        io_buffer_full,
  output state_t      dbg_state
);

  // Handshake: each requester holds its req level until its done pulse; in a
  // cycle where either done pulse is high, no request is accepted, so a level
  // that is still high during done is never taken as a new request.

  state_t      state_q, state_d;
  logic [2:0]  cnt_q, cnt_d;
  logic [2:0]  n_q, n_d;
  logic [31:0] base_q, base_d;
  logic [31:0] wdata_q, wdata_d;
  logic [23:0] buf_q, buf_d;
  logic        inst_done_d, lsb_done_d;
  logic [31:0] inst_out_d, lsb_data_d;

  logic [31:0] byte_addr;
  logic [31:0] word_rd;
  logic [7:0]  wbyte;
  logic        io_stall;

  assign dbg_state = state_q;
  assign byte_addr = base_q + {29'd0, cnt_q};
  assign io_stall  = (state_q == ST_STORE) && io_buffer_full &&
                     (byte_addr[IO_ADDR_HI:IO_ADDR_LO] == IO_SEL);

  // The final byte is taken straight from mem_din in the cnt == n cycle.
  always_comb begin
    case (n_q)
      3'd1:    word_rd = {24'd0, mem_din};
      3'd2:    word_rd = {16'd0, mem_din, buf_q[7:0]};
      default: word_rd = {mem_din, buf_q};
    endcase
  end

  always_comb begin
    case (cnt_q[1:0])
      2'd0:    wbyte = wdata_q[7:0];
      2'd1:    wbyte = wdata_q[15:8];
      2'd2:    wbyte = wdata_q[23:16];
      default: wbyte = wdata_q[31:24];
    endcase
  end

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    n_d         = n_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    buf_d       = buf_q;
    inst_done_d = 1'b0;
    lsb_done_d  = 1'b0;
    inst_out_d  = inst_out;
    lsb_data_d  = lsb_data_out;
    mem_a       = 32'd0;
    mem_dout    = 8'd0;
    mem_wr      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (!inst_done_out && !lsb_done_out) begin
          if (lsb_req_in) begin
            base_d  = lsb_addr_in;
            n_d     = size_bytes(lsb_size_in);
            wdata_d = lsb_data_in;
            cnt_d   = 3'd0;
            state_d = lsb_we_in ? ST_STORE : ST_LOAD;
          end else if (inst_req_in && !jump_wrong) begin
            base_d  = inst_pc_in;
            n_d     = INST_BYTES;
            cnt_d   = 3'd0;
            state_d = ST_INST;
          end
        end
      end

      ST_INST, ST_LOAD: begin
        if (cnt_q < n_q) mem_a = byte_addr;
        if (state_q == ST_INST && jump_wrong) begin
          state_d = ST_IDLE;
        end else if (cnt_q == n_q) begin
          state_d = ST_IDLE;
          if (state_q == ST_INST) begin
            inst_done_d = 1'b1;
            inst_out_d  = word_rd;
          end else begin
            lsb_done_d = 1'b1;
            lsb_data_d = word_rd;
          end
        end else begin
          cnt_d = cnt_q + 3'd1;
          case (cnt_q)
            3'd1:    buf_d[7:0]   = mem_din;
            3'd2:    buf_d[15:8]  = mem_din;
            3'd3:    buf_d[23:16] = mem_din;
            default: ;
          endcase
        end
      end

      ST_STORE: begin
        // A full UART buffer freezes the store on the current byte.
        if (!io_stall) begin
          mem_a    = byte_addr;
          mem_dout = wbyte;
          mem_wr   = rdy;
          if (cnt_q == n_q - 3'd1) begin
            state_d    = ST_IDLE;
            lsb_done_d = 1'b1;
          end else begin
            cnt_d = cnt_q + 3'd1;
          end
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q       <= ST_IDLE;
      cnt_q         <= 3'd0;
      n_q           <= 3'd0;
      base_q        <= 32'd0;
      wdata_q       <= 32'd0;
      buf_q         <= 24'd0;
      inst_done_out <= 1'b0;
      inst_out      <= 32'd0;
      lsb_done_out  <= 1'b0;
      lsb_data_out  <= 32'd0;
    end else if (rdy) begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      n_q           <= n_d;
      base_q        <= base_d;
      wdata_q       <= wdata_d;
      buf_q         <= buf_d;
      inst_done_out <= inst_done_d;
      inst_out      <= inst_out_d;
      lsb_done_out  <= lsb_done_d;
      lsb_data_out  <= lsb_data_d;
    end
  end

endmodule

// File: tb/tb_mem_ctrl.sv
// Bench for mem_ctrl: byte-addressed RAM model, reference memory image and a
// write scoreboard; directed scenarios followed by randomized transactions.
module tb_mem_ctrl;
  import mem_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst, rdy, jump_wrong;
  logic        inst_req_in;
  logic [31:0] inst_pc_in;
  logic        inst_done_out;
  logic [31:0] inst_out;
  logic        lsb_req_in, lsb_we_in;
  logic [31:0] lsb_addr_in;
  logic [1:0]  lsb_size_in;
  logic [31:0] lsb_data_in;
  logic        lsb_done_out;
  logic [31:0] lsb_data_out;
  logic [7:0]  mem_din, mem_dout;
  logic [31:0] mem_a;
  logic        mem_wr;
  logic        io_buffer_full;
  state_t      dbg_state;

  int n_checks = 0;
  int n_errors = 0;

  logic [39:0] exp_q[$];
  logic [7:0]  ram [int unsigned];
  logic [7:0]  ref_mem [int unsigned];

  mem_ctrl dut (
    .clk(clk), .rst(rst), .rdy(rdy), .jump_wrong(jump_wrong),
    .inst_req_in(inst_req_in), .inst_pc_in(inst_pc_in),
    .inst_done_out(inst_done_out), .inst_out(inst_out),
    .lsb_req_in(lsb_req_in), .lsb_we_in(lsb_we_in), .lsb_addr_in(lsb_addr_in),
    .lsb_size_in(lsb_size_in), .lsb_data_in(lsb_data_in),
    .lsb_done_out(lsb_done_out), .lsb_data_out(lsb_data_out),
    .mem_din(mem_din), .mem_dout(mem_dout), .mem_a(mem_a), .mem_wr(mem_wr),
    .io_buffer_full(io_buffer_full), .dbg_state(dbg_state)
  );

  // ---------------- clock / watchdog ----------------
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  function automatic logic [7:0] dflt(input logic [31:0] a);
    return a[7:0] ^ a[15:8] ^ a[31:24] ^ 8'h5A;
  endfunction

  function logic [7:0] ram_rd(input logic [31:0] a);
    return ram.exists(a) ? ram[a] : dflt(a);
  endfunction

  function logic [7:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : dflt(a);
  endfunction

  function automatic int nbytes(input logic [1:0] size);
    return (size == 2'b00) ? 1 : (size == 2'b01) ? 2 : 4;
  endfunction

  task automatic preload(input logic [31:0] a, input logic [7:0] b);
    ram[a] = b;
    ref_mem[a] = b;
  endtask

  // ---------------- RAM model + write scoreboard ----------------
  always @(posedge clk) begin
    if (mem_wr) begin
      if (exp_q.size() == 0) begin
        check("wr_unexpected", {mem_a, mem_dout}, 40'd0);
      end else begin
        check("wr_byte", {mem_a, mem_dout}, exp_q.pop_front());
      end
      ram[mem_a] = mem_dout;
    end
    mem_din <= ram_rd(mem_a);
  end

  // ---------------- driver ----------------
  // kind: 0 = fetch, 1 = load, 2 = store.
  task automatic run_txn(input int kind, input logic [31:0] addr, input logic [1:0] size,
                         input logic [31:0] data, input int stall_cycles, input bit noise);
    int n, lat, exp_lat;
    bit seen, is_io;
    logic [31:0] exp_data;
    logic [31:0] a;
    n = (kind == 0) ? 4 : nbytes(size);
    is_io = (kind == 2) && (addr[17:16] == 2'b11);
    exp_data = 32'd0;
    for (int i = 0; i < n; i++) begin
      a = addr + i;
      if (kind == 2) begin
        exp_q.push_back({a, data[8*i +: 8]});
        ref_mem[a] = data[8*i +: 8];
      end else begin
        exp_data[8*i +: 8] = ref_rd(a);
      end
    end
    exp_lat = ((kind == 2) ? n + 1 : n + 2) + (is_io ? stall_cycles : 0);

    @(negedge clk);
    if (kind == 0) begin
      inst_req_in = 1'b1;
      inst_pc_in  = addr;
    end else begin
      lsb_req_in  = 1'b1;
      lsb_we_in   = (kind == 2);
      lsb_addr_in = addr;
      lsb_size_in = size;
      lsb_data_in = data;
    end
    lat = 0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk);
      lat++;
      if (is_io) io_buffer_full = (lat <= stall_cycles);
      else       io_buffer_full = noise ? 1'($urandom_range(0, 1)) : 1'b0;
      jump_wrong = (noise && kind != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
      #1;
      if (is_io && lat <= stall_cycles) check("io_stall_wr", mem_wr, 1'b0);
      seen = (kind == 0) ? inst_done_out : lsb_done_out;
    end
    check("latency", lat, exp_lat);
    if (kind == 0)      check("inst_data", inst_out, exp_data);
    else if (kind == 1) check("load_data", lsb_data_out, exp_data);
    inst_req_in = 1'b0;
    lsb_req_in = 1'b0;
    io_buffer_full = 1'b0;
    jump_wrong = 1'b0;
    @(negedge clk);
    #1;
    check("one_pulse", {inst_done_out, lsb_done_out}, 2'b00);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int lat;
    bit seen, early;
    logic [31:0] exp_w;

    rst = 1'b1; rdy = 1'b1; jump_wrong = 1'b0;
    inst_req_in = 1'b0; inst_pc_in = 32'd0;
    lsb_req_in = 1'b0; lsb_we_in = 1'b0; lsb_addr_in = 32'd0;
    lsb_size_in = 2'b00; lsb_data_in = 32'd0; io_buffer_full = 1'b0;

    preload(32'h1000, 8'h13); preload(32'h1001, 8'h05);
    preload(32'h1002, 8'h10); preload(32'h1003, 8'h00);
    preload(32'h2003, 8'hFF);

    repeat (3) @(negedge clk);
    #1;
    check("rst_state", dbg_state, ST_IDLE);
    check("rst_outs", {inst_done_out, lsb_done_out, mem_wr, inst_out, lsb_data_out, mem_a, mem_dout},
          104'd0);
    rst = 1'b0;

    // Fetch of a known instruction word.
    run_txn(0, 32'h1000, 2'b10, 32'd0, 0, 1'b0);
    check("inst_0x1000", inst_out, 32'h0010_0513);

    // Simultaneous requests: the byte load wins, then the fetch follows.
    @(negedge clk);
    inst_req_in = 1'b1; inst_pc_in = 32'h1000;
    lsb_req_in = 1'b1; lsb_we_in = 1'b0; lsb_addr_in = 32'h2003; lsb_size_in = 2'b00;
    lat = 0; seen = 1'b0; early = 1'b0;
    while (!seen && lat < 20) begin
      @(negedge clk); lat++; #1;
      if (inst_done_out) early = 1'b1;
      seen = lsb_done_out;
    end
    check("both_lsb_lat", lat, 3);
    check("both_lsb_data", lsb_data_out, 32'h0000_00FF);
    lsb_req_in = 1'b0;
    seen = 1'b0;
    while (!seen && lat < 40) begin
      @(negedge clk); lat++; #1;
      seen = inst_done_out;
    end
    check("both_inst_lat", lat, 10);
    check("both_inst_data", inst_out, 32'h0010_0513);
    check("both_no_early_inst", early, 1'b0);
    inst_req_in = 1'b0;
    @(negedge clk);

    // Word store, then read it back.
    run_txn(2, 32'h3000, 2'b10, 32'hDEAD_BEEF, 0, 1'b0);
    run_txn(1, 32'h3000, 2'b10, 32'd0, 0, 1'b0);
    check("store_readback", lsb_data_out, 32'hDEAD_BEEF);

    // Byte store to the UART with a three-cycle full buffer.
    run_txn(2, 32'h0003_0000, 2'b00, 32'h41, 3, 1'b0);

    // Misprediction flush at cnt = 2, then a new fetch from 0x2000.
    exp_w = {ref_rd(32'h2003), ref_rd(32'h2002), ref_rd(32'h2001), ref_rd(32'h2000)};
    @(negedge clk);
    inst_req_in = 1'b1; inst_pc_in = 32'h1000;
    lat = 0; early = 1'b0;
    while (lat < 3) begin
      @(negedge clk); lat++; #1;
      if (inst_done_out) early = 1'b1;
    end
    jump_wrong = 1'b1; inst_pc_in = 32'h2000;
    @(negedge clk); lat++;
    jump_wrong = 1'b0;
    #1;
    check("jw_idle", dbg_state, ST_IDLE);
    check("jw_mem_a", mem_a, 32'd0);
    seen = 1'b0;
    while (!seen && lat < 30) begin
      @(negedge clk); lat++; #1;
      seen = inst_done_out;
    end
    check("jw_no_done", early, 1'b0);
    check("jw_new_lat", lat, 10);
    check("jw_new_data", inst_out, exp_w);
    inst_req_in = 1'b0;
    @(negedge clk);

    // Reset in the middle of a halfword load.
    @(negedge clk);
    lsb_req_in = 1'b1; lsb_we_in = 1'b0; lsb_addr_in = 32'h2002; lsb_size_in = 2'b01;
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0; lsb_req_in = 1'b0;
    #1;
    check("midrst_state", dbg_state, ST_IDLE);
    check("midrst_outs", {inst_done_out, lsb_done_out, mem_wr, inst_out, lsb_data_out, mem_a, mem_dout},
          104'd0);
    early = 1'b0;
    repeat (6) begin
      @(negedge clk); #1;
      if (lsb_done_out) early = 1'b1;
    end
    check("midrst_no_done", early, 1'b0);

    // Address wrap-around at the top of the address space.
    run_txn(1, 32'hFFFF_FFFE, 2'b10, 32'd0, 0, 1'b0);

    // Randomized traffic with jump_wrong / io_buffer_full noise on LSB ops.
    for (int t = 0; t < 60; t++) begin
      int kind;
      logic [31:0] a;
      logic [1:0] sz;
      kind = $urandom_range(0, 2);
      sz = 2'($urandom_range(0, 3));
      if ($urandom_range(0, 1) == 0) a = 32'h4000 + $urandom_range(0, 31);
      else                           a = $urandom & 32'hFFFC_FFFF;
      if (kind == 2 && $urandom_range(0, 4) == 0) a[17:16] = 2'b11;
      run_txn(kind, a, sz, $urandom, $urandom_range(0, 3), 1'b1);
    end

    check("wr_drain", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/mem_ctrl.md
MEM_CTRL -- requirements
Module: mem_ctrl

Interface
REQ-001 clk  input  1  system clock; all state changes on rising edge.
REQ-002 rst  input  1  reset, synchronous, active-high.
REQ-003 rdy  input  1  global enable; when low, all registers hold.
REQ-004 jump_wrong  input  1  misprediction flush; aborts instruction fetch only.
REQ-005 inst_req_in  input  1  instruction-fetch request from ICache, level, held until done.
REQ-006 inst_pc_in  input  32  fetch address, word-sized read.
REQ-007 inst_done_out  output  1  one-cycle pulse: inst_out valid.
REQ-008 inst_out  output  32  fetched instruction, little-endian assembly.
REQ-009 lsb_req_in  input  1  data request from load/store buffer, level, held until done.
REQ-010 lsb_we_in  input  1  1 = store, 0 = load.
REQ-011 lsb_addr_in  input  32  data byte address.
REQ-012 lsb_size_in  input  2  00 = 1 byte, 01 = 2 bytes, 10 = 4 bytes; 11 treated as 4.
REQ-013 lsb_data_in  input  32  store data, low bytes used.
REQ-014 lsb_done_out  output  1  one-cycle pulse: load data valid or store complete.
REQ-015 lsb_data_out  output  32  load data, zero-extended.
REQ-016 mem_din  input  8  RAM read byte, valid one cycle after its address.
REQ-017 mem_dout  output  8  RAM write byte.
REQ-018 mem_a  output  32  RAM byte address.
REQ-019 mem_wr  output  1  1 = write, 0 = read.
REQ-020 io_buffer_full  input  1  UART buffer full; stalls IO writes.

Function
REQ-021 States: IDLE, INST, LOAD, STORE; byte counter cnt (3 bits); byte count n from size (inst always 4).
REQ-022 IDLE: lsb_req_in has priority over inst_req_in; on accept latch addr/size/data, cnt←0, go to LOAD/STORE/INST.
REQ-023 Requests are ignored in any cycle where inst_done_out or lsb_done_out is high.
REQ-024 Read states, cycle with cnt=c: mem_a=base+c for c<n; mem_wr=0; mem_din at c≥1 is byte c-1.
REQ-025 Read: when cnt=n, last byte captured, done pulse and data registered at that edge, state←IDLE; word read from accept cycle T gives done in cycle T+6, byte read in T+3.
REQ-026 STORE, cycle with cnt=c<n: mem_a=base+c, mem_wr=1, mem_dout=data[8c+7:8c]; after byte n-1, done at next edge, state←IDLE (word store done at T+5).
REQ-027 IO stall: store with addr[17:16]==2'b11 and io_buffer_full=1: mem_wr=0, cnt holds, no byte written.
REQ-028 jump_wrong in INST: state←IDLE next edge, no inst_done_out; jump_wrong in IDLE blocks inst acceptance that cycle.
REQ-029 jump_wrong does not affect LOAD/STORE; LSB issues only non-speculative memory operations.
REQ-030 Outside read/write cycles: mem_wr=0, mem_a=0, mem_dout=0.
REQ-031 Address arithmetic is 32-bit wrap-around; no alignment requirement.

Reset
REQ-032 On rst: state=IDLE, cnt=0, inst_done_out=0, lsb_done_out=0, inst_out=0, lsb_data_out=0, mem_wr=0, mem_a=0, mem_dout=0.
REQ-033 rst mid-operation abandons the transfer; no done pulse; partial store bytes are not rolled back.

Structure
REQ-034 State encodings, size codes, IO address decode bits go in define.v shared constants.
REQ-035 Single module, no sub-module; 120-400 RTL lines.

Verification
REQ-036 Inst fetch 0x1000, RAM 0x13,0x05,0x10,0x00 -> inst_out=0x00100513, done exactly cycle T+6, one pulse.
REQ-037 Simultaneous inst and lsb byte load 0x2003 (=0xFF) -> load first, lsb_data_out=0x000000FF at T+3; inst fetch follows.
REQ-038 Word store 0xDEADBEEF to 0x3000 -> writes EF,BE,AD,DE at 0x3000..0x3003, done T+5.
REQ-039 Byte store 0x41 to 0x30000, io_buffer_full high 3 cycles -> mem_wr=0 during stall, one write after, done delayed 3 cycles.
REQ-040 jump_wrong at cnt=2 of inst fetch -> no inst_done_out, IDLE next cycle, new fetch accepted.
REQ-041 rst during halfword load -> all outputs reset values, no lsb_done_out.
